ifetch_queue: RTL and testbench
===============================

// Module: ifetch_queue
// PURPOSE
// - Decoupled, parametrised instruction-fetch front end for the next-generation Zeptron core.
// - Replaces the single-cycle fetch stage and IF/ID register.
// - Owns the PC and issues pipelined req/gnt/rvalid requests to instruction memory.
// - Buffers returned words in a DEPTH-entry queue; decode pulls them with valid/ready.
// - An EX-stage redirect (branch/jump taken) flushes the queue and discards in-flight responses.
// PARAMETERS
// - XLEN             32     PC/instruction width
// - DEPTH            4      queue entries (power of 2, >=2)
// - MAX_OUTSTANDING  2      max requests granted but not yet returned (1..DEPTH)
// - RESET_PC         'h0    PC after reset
// PORTS
// - clk            in   1     clock
// - reset          in   1     synchronous, active-high reset
// - redirect       in   1     EX branch/jump taken (e_b_taken)
// - redirect_pc    in   XLEN  target PC (e_alu_y)
// - mem_i_req      out  1     fetch request valid
// - mem_i_ra       out  XLEN  fetch address (current PC)
// - mem_i_gnt      in   1     request accepted this cycle
// - mem_i_rvalid   in   1     response valid; responses are in order
// - mem_i_rd       in   XLEN  response instruction word
// - d_valid        out  1     head entry valid
// - d_ready        in   1     decode accepts head
// - d_instr        out  XLEN  head instruction; NOP 'h00000013 when !d_valid
// - d_pc, d_pc4    out  XLEN  head PC, head PC+4
// BEHAVIOUR
// - Reset values:
//   - mem_i_req=0, mem_i_ra=RESET_PC, d_valid=0, d_instr='h13, d_pc=0, d_pc4=0.
//   - Counters, stale count and queue pointers cleared.
//   - Instruction memory shares this reset; no response arrives after reset for a pre-reset request.
// - Credit rule:
//   - mem_i_req=1 iff !reset && !redirect && outstanding<MAX_OUTSTANDING && count+outstanding<DEPTH.
//   - count excludes the entry popped this cycle.
//   - The queue therefore never overflows; rvalid into a full queue is impossible by construction.
// - On req&&gnt: pc<=pc+4 (mod 2^XLEN), outstanding++.
// - On rvalid:
//   - stale>0: drop the word, stale--.
//   - otherwise: push {mem_i_rd, pc_tag}, where pc_tag is taken from an in-order MAX_OUTSTANDING-deep tag FIFO of granted addresses.
//   - Either way outstanding--.
//   - Same-cycle gnt and rvalid: net outstanding unchanged.
// - Pop on d_valid&&d_ready.
//   - Push and pop in the same cycle are both honoured; count unchanged.
// - Latency:
//   - gnt in cycle N, rvalid in cycle M: entry visible at d_valid in M+1.
//   - With IFQ_BYPASS_EN, the entry is visible in M; see CONFIGURATION.
// - Redirect (highest priority after reset), in one cycle:
//   - queue cleared; pc<=redirect_pc; stale<=stale+outstanding-(rvalid?1:0).
//   - mem_i_req forced 0 that cycle; any rvalid that cycle is dropped.
//   - d_valid is 0 in the following cycle.
//   - Back-to-back redirects: the last one wins; stale accumulates correctly.
// - mem_i_ra holds stable while req&&!gnt. It may change only on redirect, which also withdraws req.
// - Empty: d_valid=0, d_instr=NOP, d_pc/d_pc4 hold their last values.
// CONFIGURATION
// - IFQ_BYPASS_EN defined:
//   - Queue empty, non-stale rvalid, d_ready=1: the word goes straight to d_* in the same cycle and is not written to the queue.
//   - With d_ready=0 it is queued as normal.
//   - Adds a combinational path mem_i_rd -> d_instr.
// - IFQ_BYPASS_EN undefined: all outputs are registered from queue state; minimum 1-cycle rvalid->d_valid.
// STRUCTURE
// - zeptron_pkg: fetch_entry_t {instr, pc}; NOP_INSTR='h00000013; PC_STEP=4.
// - Sub-module ifq_fifo: generic sync FIFO with parameter DEPTH and type T.
//   - Ports push/pop/clear/full/empty/count.
//   - Instanced for the entry queue and for the MAX_OUTSTANDING-deep pc tag FIFO.
// - Top level holds the PC, outstanding counter, stale counter, credit logic and output mux.
// TESTING
// 1. Reset, gnt=1, rvalid one cycle after gnt, d_ready=1 -> mem_i_ra 0,4,8,...; d_pc follows 0,4,8 back-to-back; d_pc4=d_pc+4.
// 2. d_ready=0, DEPTH=4 -> exactly 4 grants, then mem_i_req=0; count=4; release d_ready -> 4 pops in order and fetch resumes at 'h10.
// 3. Two requests outstanding, redirect to 'h200 -> the next 2 rvalids are dropped; first d_pc='h200; no stale word reaches d_instr.
// 4. Redirect in the same cycle as rvalid and again 1 cycle later -> stale count exact; final fetch stream starts at the second redirect_pc.
// 5. gnt held 0 for 5 cycles -> mem_i_req=1 and mem_i_ra stable; PC 'hFFFF_FFFC granted -> next mem_i_ra='h0 (wrap).
// 6. IFQ_BYPASS_EN, empty queue, rvalid+d_ready -> d_valid=1 in the same cycle. Without the macro -> d_valid one cycle later.

Source files
------------

// File: rtl/ifetch_queue_pkg.sv
// Shared types and constants for the Zeptron instruction-fetch queue.
package ifetch_queue_pkg;

  localparam int unsigned IFQ_XLEN  = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef struct packed {
    logic [IFQ_XLEN-1:0] instr;
    logic [IFQ_XLEN-1:0] pc;
  } fetch_entry_t;

  // Bits needed to hold a count in the range 0..n.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ifetch_queue_if.sv
// Fetch-unit bus: instruction-memory req/gnt/rvalid channel plus decode valid/ready channel.
interface ifetch_queue_if #(
  parameter int unsigned XLEN = 32
) ();

  logic            mem_i_req;
  logic [XLEN-1:0] mem_i_ra;
  logic            mem_i_gnt;
  logic            mem_i_rvalid;
  logic [XLEN-1:0] mem_i_rd;
  logic            d_valid;
  logic            d_ready;
  logic [XLEN-1:0] d_instr;
  logic [XLEN-1:0] d_pc;
  logic [XLEN-1:0] d_pc4;

  modport master (
    output mem_i_req, mem_i_ra, d_valid, d_instr, d_pc, d_pc4,
    input  mem_i_gnt, mem_i_rvalid, mem_i_rd, d_ready
  );

  modport slave (
    input  mem_i_req, mem_i_ra, d_valid, d_instr, d_pc, d_pc4,
    output mem_i_gnt, mem_i_rvalid, mem_i_rd, d_ready
  );

endinterface

// File: rtl/ifetch_queue_fifo.sv
// Generic synchronous FIFO with show-ahead output, used for entries and in-flight pc tags.
module ifq_fifo
  import ifetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type T = fetch_entry_t
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  T                           din,
  output T                           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = cnt_w(DEPTH);

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ifetch_queue.sv
// Decoupled instruction-fetch front end: PC, credit-limited pipelined fetch, entry queue, redirect flush.
// Optional IFQ_BYPASS_EN: a response into an empty queue with d_ready high is presented the same cycle.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int unsigned     XLEN            = 32,
  parameter int unsigned     DEPTH           = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  ifetch_queue_if.master  bus
);

  localparam int unsigned     CW   = cnt_w(DEPTH);
  localparam int unsigned     OW   = cnt_w(MAX_OUTSTANDING);
  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);
  localparam logic [XLEN-1:0] NOP  = XLEN'(NOP_INSTR);

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } entry_t;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] last_pc;
  logic [XLEN-1:0] last_pc4;
  logic [OW-1:0]   stale;
  logic [OW-1:0]   live;
  logic [CW-1:0]   q_count;
  logic            q_push, q_pop, q_full, q_empty;
  logic            tag_push, tag_pop, tag_full, tag_empty;
  entry_t          q_din, q_dout, head;
  logic [XLEN-1:0] tag_dout;
  logic            req, grant, rsp_live, byp, out_valid;
  logic [31:0]     in_flight, occupancy;

  // Outstanding requests are split into stale (pre-redirect) and live ones;
  // the live count is simply the occupancy of the pc tag FIFO.
  assign rsp_live = bus.mem_i_rvalid && (stale == '0) && !redirect;

`ifdef IFQ_BYPASS_EN
  assign byp = rsp_live && q_empty && bus.d_ready;
`else
  assign byp = 1'b0;
`endif

  assign q_pop    = !q_empty && bus.d_ready;
  assign q_push   = rsp_live && !byp && (!q_full || q_pop);
  assign q_din    = '{instr: bus.mem_i_rd, pc: tag_dout};
  assign tag_pop  = bus.mem_i_rvalid && (stale == '0) && !tag_empty;
  assign grant    = req && bus.mem_i_gnt;
  assign tag_push = grant && !tag_full;

  always_comb begin
    in_flight = 32'(stale) + 32'(live);
    occupancy = 32'(q_count) - 32'(q_pop) + in_flight;
    req       = !reset && !redirect
                && (in_flight < MAX_OUTSTANDING)
                && (occupancy < DEPTH);
  end

  always_comb begin
    out_valid = !q_empty || byp;
    head      = byp ? q_din : q_dout;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= redirect_pc;
    end else if (grant) begin
      pc <= pc + STEP;
    end
  end

  // On redirect every live request turns stale, less any response landing this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      stale <= '0;
    end else if (redirect) begin
      stale <= stale + live - OW'(bus.mem_i_rvalid);
    end else if (bus.mem_i_rvalid && (stale != '0)) begin
      stale <= stale - OW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_pc  <= '0;
      last_pc4 <= '0;
    end else if (out_valid) begin
      last_pc  <= head.pc;
      last_pc4 <= head.pc + STEP;
    end
  end

  ifq_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_queue (
    .clk   (clk),
    .reset (reset),
    .clear (redirect),
    .push  (q_push),
    .pop   (q_pop),
    .din   (q_din),
    .dout  (q_dout),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  ifq_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .T     (logic [XLEN-1:0])
  ) u_tags (
    .clk   (clk),
    .reset (reset),
    .clear (redirect),
    .push  (tag_push),
    .pop   (tag_pop),
    .din   (pc),
    .dout  (tag_dout),
    .full  (tag_full),
    .empty (tag_empty),
    .count (live)
  );

  assign bus.mem_i_req = req;
  assign bus.mem_i_ra  = pc;
  assign bus.d_valid   = out_valid;
  assign bus.d_instr   = out_valid ? head.instr : NOP;
  assign bus.d_pc      = out_valid ? head.pc : last_pc;
  assign bus.d_pc4     = out_valid ? head.pc + STEP : last_pc4;

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: streaming, back-pressure, redirects, stall, PC wrap and bypass latency.
module tb_ifetch_queue;

  localparam int BYP =
`ifdef IFQ_BYPASS_EN
    1;
`else
    0;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  ifetch_queue_if #(.XLEN(32)) bus ();

  ifetch_queue #(
    .XLEN            (32),
    .DEPTH           (4),
    .MAX_OUTSTANDING (2),
    .RESET_PC        (32'h0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bus         (bus)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] pend[$];
  bit          auto_gnt;
  bit          auto_rsp;
  int          grants;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a + 32'h0100_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory responder: answers granted addresses in order, one cycle after grant at the earliest.
  task drive();
    bus.mem_i_gnt = auto_gnt;
    if (auto_rsp && pend.size() > 0) begin
      bus.mem_i_rvalid = 1'b1;
      bus.mem_i_rd     = word_at(pend[0]);
    end else begin
      bus.mem_i_rvalid = 1'b0;
      bus.mem_i_rd     = '0;
    end
    #1;
  endtask

  task step();
    if (bus.mem_i_req && bus.mem_i_gnt) pend.push_back(bus.mem_i_ra);
    if (bus.mem_i_rvalid) void'(pend.pop_front());
    @(posedge clk);
    #1;
  endtask

  task do_reset();
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    auto_gnt    = 1'b0;
    auto_rsp    = 1'b0;
    bus.d_ready = 1'b0;
    pend.delete();
    drive();
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_req_in_reset", 32'(bus.mem_i_req), 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    // 1: streaming fetch with d_ready held high
    do_reset();
    auto_gnt = 1'b1; auto_rsp = 1'b1; bus.d_ready = 1'b1;
    drive();
    check("rst_d_valid", 32'(bus.d_valid), 32'd0);
    check("rst_d_instr", bus.d_instr, NOP);
    check("rst_d_pc", bus.d_pc, 32'h0);
    check("rst_d_pc4", bus.d_pc4, 32'h0);
    check("t1_req0", 32'(bus.mem_i_req), 32'd1);
    check("t1_ra0", bus.mem_i_ra, 32'h0);
    step();
    for (int k = 1; k <= 6; k++) begin
      drive();
      check("t1_ra", bus.mem_i_ra, 32'(4 * k));
      if (k >= 2 - BYP) begin
        check("t1_d_valid", 32'(bus.d_valid), 32'd1);
        check("t1_d_pc", bus.d_pc, 32'(4 * (k - 2 + BYP)));
        check("t1_d_pc4", bus.d_pc4, 32'(4 * (k - 2 + BYP) + 4));
        check("t1_d_instr", bus.d_instr, word_at(32'(4 * (k - 2 + BYP))));
      end
      step();
    end

    // 2: back-pressure fills the queue, then drains in order
    do_reset();
    auto_gnt = 1'b1; auto_rsp = 1'b1; bus.d_ready = 1'b0;
    grants = 0;
    for (int c = 0; c < 8; c++) begin
      drive();
      if (bus.mem_i_req && bus.mem_i_gnt) grants++;
      step();
    end
    check("t2_grants", 32'(grants), 32'd4);
    drive();
    check("t2_req_full", 32'(bus.mem_i_req), 32'd0);
    check("t2_head_valid", 32'(bus.d_valid), 32'd1);
    check("t2_head_pc", bus.d_pc, 32'h0);
    bus.d_ready = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      drive();
      check("t2_pop_pc", bus.d_pc, 32'(4 * i));
      check("t2_pop_instr", bus.d_instr, word_at(32'(4 * i)));
      if (i == 0) begin
        check("t2_resume_req", 32'(bus.mem_i_req), 32'd1);
        check("t2_resume_ra", bus.mem_i_ra, 32'h10);
      end
      step();
    end

    // 3: redirect with two requests in flight
    do_reset();
    auto_gnt = 1'b1; auto_rsp = 1'b0; bus.d_ready = 1'b0;
    drive(); check("t3_ra0", bus.mem_i_ra, 32'h0); step();
    drive(); check("t3_ra1", bus.mem_i_ra, 32'h4); step();
    drive(); check("t3_credit_max", 32'(bus.mem_i_req), 32'd0);
    redirect = 1'b1; redirect_pc = 32'h200;
    drive(); check("t3_req_redirect", 32'(bus.mem_i_req), 32'd0);
    step();
    redirect = 1'b0; auto_rsp = 1'b1;
    drive();
    check("t3_req_stale2", 32'(bus.mem_i_req), 32'd0);
    check("t3_dvalid_a", 32'(bus.d_valid), 32'd0);
    step();
    drive();
    check("t3_req_new", 32'(bus.mem_i_req), 32'd1);
    check("t3_ra_new", bus.mem_i_ra, 32'h200);
    check("t3_dvalid_b", 32'(bus.d_valid), 32'd0);
    check("t3_instr_nop", bus.d_instr, NOP);
    step();
    drive();
    check("t3_dvalid_c", 32'(bus.d_valid), 32'd0);
    check("t3_ra_next", bus.mem_i_ra, 32'h204);
    step();
    drive();
    check("t3_head_valid", 32'(bus.d_valid), 32'd1);
    check("t3_head_pc", bus.d_pc, 32'h200);
    check("t3_head_pc4", bus.d_pc4, 32'h204);
    check("t3_head_instr", bus.d_instr, word_at(32'h200));
    step();

    // 4: redirect coinciding with rvalid, then a second redirect
    do_reset();
    auto_gnt = 1'b1; auto_rsp = 1'b0; bus.d_ready = 1'b0;
    drive(); step();
    drive(); step();
    auto_rsp = 1'b1; redirect = 1'b1; redirect_pc = 32'h300;
    drive(); check("t4_req_r1", 32'(bus.mem_i_req), 32'd0); step();
    redirect_pc = 32'h400;
    drive(); check("t4_req_r2", 32'(bus.mem_i_req), 32'd0); step();
    redirect = 1'b0;
    drive();
    check("t4_req", 32'(bus.mem_i_req), 32'd1);
    check("t4_ra", bus.mem_i_ra, 32'h400);
    check("t4_dvalid_a", 32'(bus.d_valid), 32'd0);
    step();
    drive(); check("t4_dvalid_b", 32'(bus.d_valid), 32'd0); step();
    drive();
    check("t4_head_valid", 32'(bus.d_valid), 32'd1);
    check("t4_head_pc", bus.d_pc, 32'h400);
    check("t4_head_instr", bus.d_instr, word_at(32'h400));
    step();

    // 5: grant stall keeps address stable; PC wraps past the top of memory
    do_reset();
    auto_gnt = 1'b0; auto_rsp = 1'b0; bus.d_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      drive();
      check("t5_stall_req", 32'(bus.mem_i_req), 32'd1);
      check("t5_stall_ra", bus.mem_i_ra, 32'h0);
      step();
    end
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    drive(); step();
    redirect = 1'b0; auto_gnt = 1'b1;
    drive();
    check("t5_ra_top", bus.mem_i_ra, 32'hFFFF_FFFC);
    step();
    auto_gnt = 1'b0; auto_rsp = 1'b1;
    drive();
    check("t5_ra_wrap", bus.mem_i_ra, 32'h0);
    check("t5_req_wrap", 32'(bus.mem_i_req), 32'd1);
    step();
    drive();
    check("t5_head_pc", bus.d_pc, 32'hFFFF_FFFC);
    check("t5_head_pc4", bus.d_pc4, 32'h0);
    check("t5_head_instr", bus.d_instr, 32'h00FF_FFFC);
    step();

    // 6: response into an empty queue with decode ready
    do_reset();
    auto_gnt = 1'b1; auto_rsp = 1'b1; bus.d_ready = 1'b1;
    drive(); step();
    drive();
    check("t6_dvalid_same", 32'(bus.d_valid), 32'(BYP));
    check("t6_instr_same", bus.d_instr, (BYP != 0) ? word_at(32'h0) : NOP);
    step();
    drive();
    check("t6_dvalid_next", 32'(bus.d_valid), 32'd1);
    check("t6_pc_next", bus.d_pc, (BYP != 0) ? 32'h4 : 32'h0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
